pixel_decoder128: RTL

- Readout-side partner of the 128-pixel hit encoder.
- Detects the encoder's full flag and drives readout to drain all 128 stored 8-bit address words.
- Decodes each word back into a 128-bit hit map and presents one complete frame at a time to downstream logic.
- Frame handover uses a valid/ack handshake with backpressure.

---
 rtl/pixel_decoder128.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pixel_decoder128.sv
// Readout-side decoder for the 128-pixel hit encoder.
// Drains 128 address words per frame and rebuilds the hit map.
module pixel_decoder128 #(
    parameter int NWORDS = 128,
    parameter int NPIX   = 128
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            full_in,
    input  logic            empty_in,
    input  logic [7:0]      addr_in,
    output logic            readout,
    output logic [NPIX-1:0] hitmap,
    output logic [7:0]      hit_count,
    output logic            frame_valid,
    input  logic            frame_ack,
    output logic            err_short
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            readout_q, readout_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            fv_q, fv_d;
    logic            err_q, err_d;
    logic            clr;

    logic            rd_d1_q, rd_d1_d;
    logic            cap_vld_q, cap_vld_d;
    logic [7:0]      cap_word_q, cap_word_d;

    logic [NPIX-1:0] hitmap_q, hitmap_d;
    logic [7:0]      count_q, count_d;
    logic [6:0]      idx;

    // Frame control: arm on full, issue NWORDS strobes, drain, hold.
    always_comb begin
        state_d   = state_q;
        readout_d = readout_q;
        cnt_d     = cnt_q;
        fv_d      = fv_q;
        err_d     = err_q;
        clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                readout_d = 1'b0;
                fv_d      = 1'b0;
                if (full_in && !fv_q) begin
                    clr       = 1'b1;
                    cnt_d     = '0;
                    readout_d = 1'b1;
                    state_d   = READ;
                end
            end
            READ: begin
                if (readout_q) begin
                    cnt_d = cnt_q + 7'd1;
                end
                if (cnt_q == 7'(NWORDS - 1)) begin
                    readout_d = 1'b0;
                    state_d   = DRAIN;
                end else if (!full_in) begin
                    readout_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    readout_d = 1'b1;
                end
            end
            DRAIN: begin
                readout_d = 1'b0;
                state_d   = HOLD;
            end
            HOLD: begin
                readout_d = 1'b0;
                fv_d      = 1'b1;
                if (fv_q && frame_ack) begin
                    fv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                readout_d = 1'b0;
                fv_d      = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Encoder words appear one cycle after the strobe; rd_d1 marks them.
    always_comb begin
        rd_d1_d    = readout_q;
        cap_vld_d  = rd_d1_q;
        cap_word_d = cap_word_q;
        if (rd_d1_q) begin
            cap_word_d = addr_in;
        end
    end

    // Set the addressed pixel; count only first-time hits, saturating.
    always_comb begin
        hitmap_d = hitmap_q;
        count_d  = count_q;
        idx      = {cap_word_q[7:4], cap_word_q[2:0]};
        if (clr) begin
            hitmap_d = '0;
            count_d  = '0;
        end else if (cap_vld_q && cap_word_q[3] && !hitmap_q[idx]) begin
            hitmap_d[idx] = 1'b1;
            if (count_q < 8'(NPIX)) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            readout_q  <= 1'b0;
            cnt_q      <= '0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            rd_d1_q    <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_word_q <= '0;
            hitmap_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            readout_q  <= readout_d;
            cnt_q      <= cnt_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            rd_d1_q    <= rd_d1_d;
            cap_vld_q  <= cap_vld_d;
            cap_word_q <= cap_word_d;
            hitmap_q   <= hitmap_d;
            count_q    <= count_d;
        end
    end

    assign readout     = readout_q;
    assign hitmap      = hitmap_q;
    assign hit_count   = count_q;
    assign frame_valid = fv_q;
    assign err_short   = err_q;

    // After a complete 128-word drain the counter has wrapped to zero
    // and the encoder must be reporting empty.
    a_empty_after_last: assert property (
        @(posedge clk) disable iff (!reset_n)
        (state_q == DRAIN && cnt_q == 7'd0) |-> empty_in
    );

endmodule
